// File: rtl/adc_bcd_formatter_pkg.sv
// ----------------------------------------------------------------------------
// adc_disp_pkg
//   Shared constants and types for the ADC display path: digit geometry,
//   decimal-point position, saturation default, converter FSM states and
//   the leading-zero blank-mask helper.
//   No ports (package).
// ----------------------------------------------------------------------------
package adc_disp_pkg;

    localparam int unsigned DIG_N       = 6;      // digits on the display
    localparam int unsigned DIG_W       = 4;      // bits per BCD digit
    localparam int unsigned DP_DIGIT    = 3;      // digit carrying the decimal point
    localparam int unsigned BCD_W       = DIG_N * DIG_W;
    localparam int unsigned MAX_VAL_DEF = 999999; // largest value six digits can show

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fmt_state_e;

    // Blank each digit above the point digit that is zero with only zeros
    // above it. Digits at or below the point digit are never blanked.
    function automatic logic [DIG_N-1:0] lead_zero_mask(input logic [BCD_W-1:0] dig);
        logic [DIG_N-1:0] mask;
        logic             run;
        int unsigned      idx;
        mask = '0;
        run  = 1'b1;
        for (int unsigned i = 0; i < DIG_N - DP_DIGIT - 1; i++) begin
            idx  = DIG_N - 1 - i;
            run  = run & (DIG_W'(dig >> (idx * DIG_W)) == '0);
            mask = mask | (DIG_N'(run) << idx);
        end
        return mask;
    endfunction

endpackage

// File: rtl/adc_bcd_formatter_if.sv
// ----------------------------------------------------------------------------
// adc_bcd_formatter_if
//   Handshake and result bus between a requester and adc_bcd_formatter.
//   Signals:
//     iSTART  request conversion of iDATA (honoured only while oBUSY=0)
//     iDATA   unsigned binary value, IN_W bits
//     oBUSY   conversion in progress
//     oDONE   one-cycle completion pulse, oDIG valid from this cycle
//     oDIG    packed BCD, [23:20]=MSD .. [3:0]=LSD, held between conversions
//     oOVF    input exceeded the saturation ceiling
//     oBLANK  per-digit leading-zero blank mask
//   Modports: master (requester side), slave (formatter side).
// ----------------------------------------------------------------------------
interface adc_bcd_formatter_if #(
    parameter int unsigned IN_W = 20
);
    import adc_disp_pkg::*;

    logic                 iSTART;
    logic [IN_W-1:0]      iDATA;
    logic                 oBUSY;
    logic                 oDONE;
    logic [BCD_W-1:0]     oDIG;
    logic                 oOVF;
    logic [DIG_N-1:0]     oBLANK;

    modport master (
        output iSTART, iDATA,
        input  oBUSY, oDONE, oDIG, oOVF, oBLANK
    );

    modport slave (
        input  iSTART, iDATA,
        output oBUSY, oDONE, oDIG, oOVF, oBLANK
    );

endinterface

// File: rtl/adc_bcd_formatter_add3.sv
// ----------------------------------------------------------------------------
// bcd_add3_nibble
//   Combinational double-dabble correction cell: a BCD digit of 5 or more
//   gets +3 so that the following left shift carries correctly into the
//   next digit. No carry leaves the nibble.
//   Ports:
//     din   in  DIG_W  digit before correction
//     dout  out DIG_W  corrected digit
// ----------------------------------------------------------------------------
module bcd_add3_nibble
    import adc_disp_pkg::*;
(
    input  logic [DIG_W-1:0] din,
    output logic [DIG_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= DIG_W'(5)) begin
            dout = din + DIG_W'(3);
        end
    end

endmodule

// File: rtl/adc_bcd_formatter.sv
// ----------------------------------------------------------------------------
// adc_bcd_formatter
//   Sequential binary-to-BCD converter (double-dabble, one bit per clock)
//   producing six packed BCD digits for the seven-segment LUT bank.
//   Inputs above MAX_VAL are saturated to MAX_VAL and flagged with oOVF.
//   Ports:
//     iCLK    in   system clock, rising edge
//     iRST_N  in   asynchronous active-low reset
//     bus     slave modport of adc_bcd_formatter_if (start/data/busy/done,
//             BCD result, overflow flag, blank mask)
//   Configuration:
//     ADC_BCD_LEADING_ZERO_BLANK_EN  when defined, oBLANK marks leading zero
//     digits above the point digit; when undefined oBLANK is constant zero.
// ----------------------------------------------------------------------------
module adc_bcd_formatter
    import adc_disp_pkg::*;
#(
    parameter int unsigned IN_W    = 20,
    parameter int unsigned MAX_VAL = MAX_VAL_DEF
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    adc_bcd_formatter_if.slave bus
);

    localparam int unsigned     CNT_W = $clog2(IN_W + 1);
    localparam logic [IN_W-1:0] MAX_V = IN_W'(MAX_VAL);

    fmt_state_e       state;
    fmt_state_e       state_nxt;

    logic [IN_W-1:0]  bin;
    logic [BCD_W-1:0] bcd;
    logic [BCD_W-1:0] bcd_adj;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [BCD_W-1:0] dig_q;
    logic             ovf_q;
    logic             done_q;
    logic             busy;
    logic             accept;
    logic             ovf_in;

    // Per-digit add-3 correction applied before every shift
    for (genvar g = 0; g < DIG_N; g++) begin : g_add3
        bcd_add3_nibble u_add3 (
            .din  (bcd[g*DIG_W +: DIG_W]),
            .dout (bcd_adj[g*DIG_W +: DIG_W])
        );
    end

    assign ovf_in = (bus.iDATA > MAX_V);

    // FSM state register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and control
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.iSTART) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shift registers, bit counter and result registers. oDONE is registered
    // at the DONE edge so it rises together with the new oDIG and lands in
    // the following IDLE cycle; a held iSTART is then accepted on that same
    // cycle's closing edge.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bin    <= '0;
            bcd    <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            dig_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                bin <= ovf_in ? MAX_V : bus.iDATA;
                bcd <= '0;
                ovf <= ovf_in;
                cnt <= CNT_W'(IN_W);
            end else if (state == SHIFT) begin
                {bcd, bin} <= {bcd_adj[BCD_W-2:0], bin, 1'b0};
                cnt        <= cnt - CNT_W'(1);
            end else if (state == DONE) begin
                dig_q  <= bcd;
                ovf_q  <= ovf;
                done_q <= 1'b1;
            end
        end
    end

`ifdef ADC_BCD_LEADING_ZERO_BLANK_EN
    logic [DIG_N-1:0] blank_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            blank_q <= '0;
        end else if (state == DONE) begin
            blank_q <= lead_zero_mask(bcd);
        end
    end

    assign bus.oBLANK = blank_q;
`else
    assign bus.oBLANK = '0;
`endif

    assign bus.oBUSY = busy;
    assign bus.oDONE = done_q;
    assign bus.oDIG  = dig_q;
    assign bus.oOVF  = ovf_q;

endmodule

// File: tb/tb_adc_bcd_formatter.sv
module tb_adc_bcd_formatter;

    logic clk;
    logic rst_n;

    int unsigned total;
    int unsigned passed;
    int unsigned failed;

    adc_bcd_formatter_if #(.IN_W(20)) bus ();

    adc_bcd_formatter #(
        .IN_W    (20),
        .MAX_VAL (999999)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start a conversion at a falling edge, scramble iDATA once accepted and
    // count rising edges after the accept edge until oDONE is seen (max 40).
    task automatic convert(input logic [19:0] val, output int edges);
        @(negedge clk);
        bus.iSTART = 1'b1;
        bus.iDATA  = val;
        @(negedge clk);
        bus.iSTART = 1'b0;
        bus.iDATA  = ~val;
        chk("busy_after_accept", 32'(bus.oBUSY), 32'd1);
        edges = 0;
        while (!bus.oDONE && edges < 40) begin
            @(negedge clk);
            edges++;
        end
    endtask

    initial begin
        int          edges;
        int          pulses;
        int          first_at;
        int          second_at;
        logic [23:0] seen_dig;
        logic [5:0]  bl_42;
        logic [5:0]  bl_0;
        logic [5:0]  bl_10k;

`ifdef ADC_BCD_LEADING_ZERO_BLANK_EN
        bl_42  = 6'b110000;
        bl_0   = 6'b110000;
        bl_10k = 6'b100000;
`else
        bl_42  = 6'b000000;
        bl_0   = 6'b000000;
        bl_10k = 6'b000000;
`endif

        total      = 0;
        passed     = 0;
        failed     = 0;
        rst_n      = 1'b0;
        bus.iSTART = 1'b0;
        bus.iDATA  = '0;

        // Reset state
        #1;
        chk("rst_busy",  32'(bus.oBUSY),  32'd0);
        chk("rst_done",  32'(bus.oDONE),  32'd0);
        chk("rst_dig",   32'(bus.oDIG),   32'h000000);
        chk("rst_ovf",   32'(bus.oOVF),   32'd0);
        chk("rst_blank", 32'(bus.oBLANK), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Zero input, latency of 21 edges after acceptance
        convert(20'd0, edges);
        chk("lat_0",   32'(edges),      32'd21);
        chk("dig_0",   32'(bus.oDIG),   32'h000000);
        chk("ovf_0",   32'(bus.oOVF),   32'd0);
        chk("blank_0", 32'(bus.oBLANK), 32'(bl_0));
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.oDONE), 32'd0);
        chk("idle_not_busy",  32'(bus.oBUSY), 32'd0);

        convert(20'd123456, edges);
        chk("lat_123456",   32'(edges),      32'd21);
        chk("dig_123456",   32'(bus.oDIG),   32'h123456);
        chk("blank_123456", 32'(bus.oBLANK), 32'd0);

        convert(20'd999999, edges);
        chk("dig_999999", 32'(bus.oDIG), 32'h999999);
        chk("ovf_999999", 32'(bus.oOVF), 32'd0);

        // Saturation
        convert(20'hFFFFF, edges);
        chk("dig_sat", 32'(bus.oDIG), 32'h999999);
        chk("ovf_sat", 32'(bus.oOVF), 32'd1);
        @(negedge clk);
        chk("ovf_held", 32'(bus.oOVF), 32'd1);

        convert(20'd7, edges);
        chk("dig_7", 32'(bus.oDIG), 32'h000007);
        chk("ovf_7", 32'(bus.oOVF), 32'd0);

        convert(20'd42, edges);
        chk("dig_42",   32'(bus.oDIG),   32'h000042);
        chk("blank_42", 32'(bus.oBLANK), 32'(bl_42));

        convert(20'd10000, edges);
        chk("dig_10000",   32'(bus.oDIG),   32'h010000);
        chk("blank_10000", 32'(bus.oBLANK), 32'(bl_10k));

        // Start while busy is dropped
        @(negedge clk);
        bus.iSTART = 1'b1;
        bus.iDATA  = 20'd500;
        @(negedge clk);
        bus.iSTART = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_at_second_start", 32'(bus.oBUSY), 32'd1);
        bus.iSTART = 1'b1;
        bus.iDATA  = 20'd777;
        @(negedge clk);
        bus.iSTART = 1'b0;
        pulses   = 0;
        seen_dig = '0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (bus.oDONE) begin
                pulses++;
                seen_dig = bus.oDIG;
            end
        end
        chk("busy_pulses", 32'(pulses),   32'd1);
        chk("busy_dig",    32'(seen_dig), 32'h000500);

        // Held start: one conversion every 22 cycles
        @(negedge clk);
        bus.iSTART = 1'b1;
        bus.iDATA  = 20'd321;
        first_at   = -1;
        second_at  = -1;
        for (int i = 0; i < 80 && second_at < 0; i++) begin
            @(negedge clk);
            if (bus.oDONE) begin
                if (first_at < 0) first_at = i;
                else second_at = i;
            end
        end
        chk("held_dig",    32'(bus.oDIG),             32'h000321);
        chk("held_period", 32'(second_at - first_at), 32'd22);
        bus.iSTART = 1'b0;
        for (int i = 0; i < 40 && (bus.oBUSY || bus.oDONE); i++) begin
            @(negedge clk);
        end
        chk("held_drained", 32'(bus.oBUSY), 32'd0);

        // Reset during SHIFT aborts with no completion
        convert(20'd7, edges);
        chk("pre_abort_dig", 32'(bus.oDIG), 32'h000007);
        @(negedge clk);
        bus.iSTART = 1'b1;
        bus.iDATA  = 20'd555555;
        @(negedge clk);
        bus.iSTART = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.oBUSY), 32'd0);
        chk("abort_dig",  32'(bus.oDIG),  32'h000000);
        chk("abort_done", 32'(bus.oDONE), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.oDONE) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);

        convert(20'd123, edges);
        chk("post_abort_lat", 32'(edges),    32'd21);
        chk("post_abort_dig", 32'(bus.oDIG), 32'h000123);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
